vram_arbiter: RTL and testbench

- Shares a single-port, 1-cycle-latency video RAM between display scan-out and a CPU requester.
- Display fetches are driven by the X/Y/HB/VB outputs of the VGA timing generator. They are hard-scheduled slots with absolute priority.
- The CPU is served in all other cycles through a REQ/ACK handshake.
- The block unpacks fetched words into a registered pixel stream, PIX, for the DAC/palette stage.

---
 rtl/vram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_vram_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: hard-scheduled display fetch slots plus a REQ/ACK CPU port
// sharing one single-port, 1-cycle-latency VRAM; unpacks words into a pixel stream.
module vram_arbiter #(
  parameter int W    = 640,
  parameter int H    = 480,
  parameter int BPP  = 2,
  parameter int DW   = 16,
  parameter int AW   = 16,
  parameter int BASE = 0
) (
  input  logic                 CLK,
  input  logic                 RST_,
  input  logic [$clog2(W)-1:0] X,
  input  logic [$clog2(H)-1:0] Y,
  input  logic                 HB,
  input  logic                 VB,
  output logic [BPP-1:0]       PIX,
  output logic                 DE,
  input  logic                 C_REQ,
  input  logic                 C_WE,
  input  logic [AW-1:0]        C_ADDR,
  input  logic [DW-1:0]        C_WDATA,
  output logic                 C_ACK,
  output logic [DW-1:0]        C_RDATA,
  output logic                 M_EN,
  output logic                 M_WE,
  output logic [AW-1:0]        M_ADDR,
  output logic [DW-1:0]        M_WDATA,
  input  logic [DW-1:0]        M_RDATA
);

  // state   | meaning
  // IDLE    | free; a CPU request is issued here when no display slot is active
  // WAIT    | VRAM returns the CPU read data; captured into C_RDATA
  // ACK     | C_ACK high for one cycle; C_REQ ignored
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} cpu_state_t;

  localparam int XW  = $clog2(W);
  localparam int YW  = $clog2(H);
  localparam int PPW = DW / BPP;
  localparam int PSH = $clog2(PPW);
  localparam int WPL = W / PPW;

  localparam logic [XW-1:0]     X_LINE    = XW'(W);
  localparam logic [YW-1:0]     Y_LAST    = YW'(H - 1);
  localparam logic [AW-1:0]     BASE_A    = AW'(BASE);
  localparam logic [AW-1:0]     WPL_A     = AW'(WPL);
  localparam logic [XW-PSH:0]   WORD_LAST = (XW-PSH+1)'(WPL - 1);
  localparam logic [PSH-1:0]    SUB_LAST  = '1;

  cpu_state_t        state;
  logic [PSH-1:0]    xsub;
  logic [XW-PSH-1:0] xword;
  logic              active;
  logic              line_slot;
  logic              word_slot;
  logic              cpu_issue;
  logic [AW-1:0]     row;
  logic [AW-1:0]     nrow;
  logic [DW-1:0]     cur;
  logic [DW-1:0]     nxt;
  logic              valid;
  logic              line_tag;
  logic              word_tag;
  logic              we_q;

  assign xsub      = X[PSH-1:0];
  assign xword     = X[XW-1:PSH];
  assign active    = !HB && !VB;
  assign line_slot = HB && (X == X_LINE);
  assign word_slot = active && (xsub == '0) && ({1'b0, xword} < WORD_LAST);
  assign nrow      = (Y >= Y_LAST) ? BASE_A : row + WPL_A;
  assign cpu_issue = (state == S_IDLE) && C_REQ && !line_slot && !word_slot;

  // The strobe is held off while reset is asserted so no access leaks out of reset.
  always_comb begin
    M_EN    = 1'b0;
    M_WE    = 1'b0;
    M_ADDR  = '0;
    M_WDATA = '0;
    if (RST_) begin
      if (line_slot) begin
        M_EN   = 1'b1;
        M_ADDR = nrow;
      end else if (word_slot) begin
        M_EN   = 1'b1;
        M_ADDR = row + AW'(xword) + AW'(1);
      end else if (cpu_issue) begin
        M_EN    = 1'b1;
        M_WE    = C_WE;
        M_ADDR  = C_ADDR;
        M_WDATA = C_WE ? C_WDATA : '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      row      <= BASE_A;
      cur      <= '0;
      nxt      <= '0;
      valid    <= 1'b0;
      line_tag <= 1'b0;
      word_tag <= 1'b0;
      PIX      <= '0;
      DE       <= 1'b0;
    end else begin
      line_tag <= line_slot;
      word_tag <= word_slot;
      if (line_slot)
        row <= nrow;
      if (active && (xsub == SUB_LAST))
        cur <= nxt;
      // Returns never coincide with a shift: line data lands in blanking and
      // word data lands one pixel into the word.
      if (line_tag) begin
        cur   <= M_RDATA;
        valid <= 1'b1;
      end
      if (word_tag)
        nxt <= M_RDATA;
      DE  <= active;
      PIX <= (active && valid) ? cur[xsub*BPP +: BPP] : '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      state   <= S_IDLE;
      C_ACK   <= 1'b0;
      C_RDATA <= '0;
      we_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          C_ACK <= 1'b0;
          if (cpu_issue) begin
            we_q  <= C_WE;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!we_q)
            C_RDATA <= M_RDATA;
          C_ACK <= 1'b1;
          state <= S_ACK;
        end
        S_ACK: begin
          C_ACK <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          C_ACK <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter: drives a small VGA-style raster and a CPU
// requester, models the VRAM, and checks slots, grants, ACKs and pixels.
module tb_vram_arbiter;

  localparam int W    = 48;
  localparam int H    = 6;
  localparam int BPP  = 2;
  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int BASE = 16;
  localparam int PPW  = DW / BPP;
  localparam int WPL  = W / PPW;
  localparam int XW   = $clog2(W);
  localparam int YW   = $clog2(H);
  localparam int HT   = 64;
  localparam int VT   = 8;
  localparam int FR   = HT * VT;

  logic           CLK;
  logic           RST_;
  logic [XW-1:0]  X;
  logic [YW-1:0]  Y;
  logic           HB;
  logic           VB;
  logic [BPP-1:0] PIX;
  logic           DE;
  logic           C_REQ;
  logic           C_WE;
  logic [AW-1:0]  C_ADDR;
  logic [DW-1:0]  C_WDATA;
  logic           C_ACK;
  logic [DW-1:0]  C_RDATA;
  logic           M_EN;
  logic           M_WE;
  logic [AW-1:0]  M_ADDR;
  logic [DW-1:0]  M_WDATA;
  logic [DW-1:0]  M_RDATA;

  vram_arbiter #(.W(W), .H(H), .BPP(BPP), .DW(DW), .AW(AW), .BASE(BASE)) dut (
    .CLK(CLK), .RST_(RST_), .X(X), .Y(Y), .HB(HB), .VB(VB), .PIX(PIX), .DE(DE),
    .C_REQ(C_REQ), .C_WE(C_WE), .C_ADDR(C_ADDR), .C_WDATA(C_WDATA),
    .C_ACK(C_ACK), .C_RDATA(C_RDATA), .M_EN(M_EN), .M_WE(M_WE),
    .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_RDATA(M_RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [DW-1:0] vram [0:255];
  int            checks, errors;
  int            gx, gy, cyc, fr, px, py;
  int            last_issue, ack_due, p_req, force_kind, rst_off;
  logic          req_hi, req_we, rd_chk, scramble;
  logic          prev_act, prev_shown, shown;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata, exp_rd;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d x=%0d y=%0d", tag, got, exp, cyc, gx, gy);
    end
  endtask

  function automatic logic [BPP-1:0] pixel(int x, int y);
    logic [DW-1:0] w;
    w = vram[BASE + y*WPL + x/PPW];
    return w[(x%PPW)*BPP +: BPP];
  endfunction

  // One raster cycle: drive at posedge+1, check at negedge, memory update after posedge.
  task automatic step();
    logic          act, is_line, is_word, exp_iss, m_en_s, m_we_s;
    logic [AW-1:0] exp_a, ma;
    logic [DW-1:0] mwd;
    if (scramble && gy == H && gx == 0) begin
      for (int k = 0; k < H*WPL; k++) vram[BASE+k] = DW'($urandom);
      scramble = 1'b0;
    end
    if (fr == 1 && gy == 3 && gx == 0) force_kind = 2;
    if (!req_hi && (force_kind != 0 || $urandom_range(99) < p_req)) begin
      req_hi = 1'b1;
      if (force_kind == 2) begin
        req_we = 1'b1; req_addr = AW'(BASE + 3); req_wdata = DW'($urandom);
      end else if (force_kind == 1) begin
        req_we = 1'b0; req_addr = AW'($urandom);
      end else begin
        req_we    = 1'($urandom_range(1));
        req_addr  = req_we ? AW'($urandom_range(64, 255)) : AW'($urandom);
        req_wdata = DW'($urandom);
      end
      force_kind = 0;
    end
    C_REQ = req_hi; C_WE = req_we; C_ADDR = req_addr; C_WDATA = req_wdata;
    X = XW'(gx); Y = YW'(gy); HB = (gx >= W); VB = (gy >= H);
    act = !HB && !VB;

    @(negedge CLK);
    chk("de", 32'(DE), 32'(prev_act));
    chk("pix", 32'(PIX), (prev_act && prev_shown) ? 32'(pixel(px, py)) : 32'd0);
    is_line = HB && (gx == W);
    is_word = act && (gx % PPW == 0) && (gx/PPW + 1 < WPL);
    if (is_line || is_word) begin
      exp_a = is_line ? ((gy >= H-1) ? AW'(BASE) : AW'(BASE + (gy+1)*WPL))
                      : AW'(BASE + gy*WPL + gx/PPW + 1);
      chk(is_line ? "line_slot" : "word_slot", 32'({M_EN, M_WE, M_ADDR, M_WDATA}),
          32'({1'b1, 1'b0, exp_a, {DW{1'b0}}}));
    end else begin
      exp_iss = req_hi && (cyc - last_issue >= 3);
      chk("cpu_issue", 32'(M_EN), 32'(exp_iss));
      if (exp_iss) begin
        chk("cpu_cmd", 32'({M_WE, M_ADDR, M_WDATA}),
            32'({req_we, req_addr, req_we ? req_wdata : {DW{1'b0}}}));
        last_issue = cyc;
        ack_due    = cyc + 2;
        rd_chk     = !req_we;
        exp_rd     = vram[req_addr];
      end
    end
    chk("c_ack", 32'(C_ACK), 32'(cyc == ack_due));
    if (cyc == ack_due) begin
      if (rd_chk) chk("c_rdata", 32'(C_RDATA), 32'(exp_rd));
      req_hi = 1'b0;
      C_REQ  = 1'b0;
    end
    if (rst_off != 0 && cyc - last_issue == rst_off) begin
      RST_ = 1'b0;
      #1;
      chk("rst_ack", 32'(C_ACK), 32'd0);
      chk("rst_men", 32'(M_EN), 32'd0);
      req_hi = 1'b0; C_REQ = 1'b0;
      ack_due = -1; last_issue = -100; rst_off = 0;
    end
    m_en_s = M_EN; m_we_s = M_WE; ma = M_ADDR; mwd = M_WDATA;

    @(posedge CLK);
    #1;
    if (m_en_s) begin
      if (m_we_s) vram[ma] = mwd;
      else        M_RDATA  = vram[ma];
    end
    cyc++;
    if (!RST_) begin
      RST_ = 1'b1;
      gx = 0; gy = 0;
      prev_act = 1'b0; prev_shown = 1'b0; shown = 1'b0;
    end else begin
      prev_act = act; prev_shown = shown; px = gx; py = gy;
      if (is_line) shown = 1'b1;
      if (gx == HT-1) begin
        gx = 0;
        if (gy == VT-1) begin gy = 0; fr++; end
        else gy++;
      end else gx++;
    end
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  initial begin
    checks = 0; errors = 0;
    gx = 0; gy = 0; cyc = 0; fr = 0; px = 0; py = 0;
    last_issue = -100; ack_due = -1; p_req = 30; force_kind = 0; rst_off = 0;
    req_hi = 0; req_we = 0; rd_chk = 0; scramble = 1;
    prev_act = 0; prev_shown = 0; shown = 0;
    req_addr = '0; req_wdata = '0; exp_rd = '0;
    for (int k = 0; k < 256; k++) vram[k] = DW'(k);
    RST_ = 0; X = '0; Y = '0; HB = 0; VB = 0;
    C_REQ = 0; C_WE = 0; C_ADDR = '0; C_WDATA = '0; M_RDATA = '0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_pix", 32'(PIX), 32'd0);
    chk("rst_de", 32'(DE), 32'd0);
    chk("rst_ack", 32'(C_ACK), 32'd0);
    chk("rst_rdata", 32'(C_RDATA), 32'd0);
    chk("rst_men", 32'({M_EN, M_WE}), 32'd0);
    @(posedge CLK);
    #1;
    RST_ = 1;

    run(FR);                 // frame 0: word k = k, light CPU traffic
    p_req = 100;
    run(FR);                 // frame 1: back-to-back CPU, write to BASE+3
    p_req = 30;
    run(FR);                 // frame 2: shows the written word

    p_req = 0;
    run(10);
    force_kind = 1; rst_off = 2;   // reset while C_ACK is high
    run(20);
    force_kind = 1; rst_off = 1;   // reset while the read data is returning
    run(20);
    p_req = 40;
    run(FR + 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
